// File: rtl/uart_rx_frame_pkg.sv
// Shared definitions for the UART receive path: FSM state codes, parity modes,
// the baud divider computation and the 3-sample majority vote.
package uart_rx_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Clocks per oversample tick, truncated.
  function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
    return clk_hz / (baud * oversample);
  endfunction

  function automatic logic vote3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle pulse every DIV clocks, held at zero while clr is high
// so the first tick after clr drops lands exactly DIV clocks later.
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic CLK_50MHZ,
  input  logic RST,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_reg;
  logic          wrap;

  assign wrap = (cnt_reg == CW'(DIV - 1));
  assign tick = wrap & ~clr;

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      cnt_reg <= '0;
    end else if (clr || wrap) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver: 2-flop synchronizer, 16x oversampled mid-bit majority vote, 8 data bits
// LSB-first with optional parity, and a one-deep holding register with valid/ready handshake.
module uart_rx_frame
  import uart_rx_frame_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = PARITY_NONE
) (
  input  logic       CLK_50MHZ,
  input  logic       RST,
  input  logic       RS232_DCE_RXD,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  input  logic       RX_READY,
  output logic       RX_FERR,
  output logic       RX_PERR,
  output logic       RX_OVERRUN,
  output logic       RX_BUSY
);

  localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int MID = OVERSAMPLE / 2;
  localparam int SW  = $clog2(OVERSAMPLE);

  logic            rxd_meta_reg;
  logic            rxd_s_reg;
  logic [1:0]      settle_reg;
  logic            rxd_prev_reg;

  rx_state_t       state_reg;
  logic [SW-1:0]   samp_reg;
  logic [2:0]      bit_reg;
  logic [7:0]      shift_reg;
  logic [1:0]      vote_reg;
  logic            perr_reg;

  logic [7:0]      rx_data_reg;
  logic            rx_valid_reg;
  logic            rx_ferr_reg;
  logic            rx_perr_reg;
  logic            rx_overrun_reg;
  logic            rx_busy_reg;

  logic            tick;
  logic            sampling;
  logic [SW-1:0]   samp_next;
  logic            decide;
  logic            vote;
  logic            fall;
  logic            exp_par;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .CLK_50MHZ (CLK_50MHZ),
    .RST       (RST),
    .clr       (state_reg == ST_IDLE),
    .tick      (tick)
  );

  // The prev flop only starts tracking once the synchronizer has flushed its preset ones,
  // so a line already low at reset release is not mistaken for a start edge.
  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      rxd_meta_reg <= 1'b1;
      rxd_s_reg    <= 1'b1;
      settle_reg   <= 2'b00;
      rxd_prev_reg <= 1'b0;
    end else begin
      rxd_meta_reg <= RS232_DCE_RXD;
      rxd_s_reg    <= rxd_meta_reg;
      settle_reg   <= {settle_reg[0], 1'b1};
      rxd_prev_reg <= settle_reg[1] & rxd_s_reg;
    end
  end

  assign fall      = rxd_prev_reg & ~rxd_s_reg;
  assign sampling  = (state_reg != ST_IDLE) && (state_reg != ST_BREAK);
  assign samp_next = (samp_reg == SW'(OVERSAMPLE - 1)) ? '0 : samp_reg + SW'(1);
  assign decide    = tick && sampling && (samp_next == SW'(MID + 1));
  assign vote      = vote3(vote_reg[0], vote_reg[1], rxd_s_reg);
  assign exp_par   = (PARITY == PARITY_ODD) ? ~(^shift_reg) : ^shift_reg;

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      state_reg      <= ST_IDLE;
      samp_reg       <= '0;
      bit_reg        <= 3'd0;
      shift_reg      <= 8'h00;
      vote_reg       <= 2'b00;
      perr_reg       <= 1'b0;
      rx_data_reg    <= 8'h00;
      rx_valid_reg   <= 1'b0;
      rx_ferr_reg    <= 1'b0;
      rx_perr_reg    <= 1'b0;
      rx_overrun_reg <= 1'b0;
      rx_busy_reg    <= 1'b0;
    end else begin
      rx_overrun_reg <= 1'b0;
      if (rx_valid_reg && RX_READY) begin
        rx_valid_reg <= 1'b0;
      end

      if (tick && sampling) begin
        samp_reg <= samp_next;
        if (samp_next == SW'(MID - 1)) vote_reg[0] <= rxd_s_reg;
        if (samp_next == SW'(MID))     vote_reg[1] <= rxd_s_reg;
      end

      case (state_reg)
        ST_IDLE: begin
          if (fall) begin
            state_reg   <= ST_START;
            samp_reg    <= '0;
            rx_busy_reg <= 1'b1;
          end
        end
        ST_START: begin
          if (decide) begin
            if (vote) begin
              state_reg   <= ST_IDLE;
              rx_busy_reg <= 1'b0;
            end else begin
              state_reg <= ST_DATA;
              bit_reg   <= 3'd0;
              perr_reg  <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (decide) begin
            shift_reg <= {vote, shift_reg[7:1]};
            bit_reg   <= bit_reg + 3'd1;
            if (bit_reg == 3'd7) begin
              state_reg <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end
          end
        end
        ST_PARITY: begin
          if (decide) begin
            perr_reg  <= (vote != exp_par);
            state_reg <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (decide) begin
            // A full holding register keeps its byte; the new one is dropped and flagged.
            if (!rx_valid_reg || RX_READY) begin
              rx_data_reg  <= shift_reg;
              rx_ferr_reg  <= ~vote;
              rx_perr_reg  <= perr_reg;
              rx_valid_reg <= 1'b1;
            end else begin
              rx_overrun_reg <= 1'b1;
            end
            if (vote) begin
              state_reg   <= ST_IDLE;
              rx_busy_reg <= 1'b0;
            end else begin
              state_reg <= ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          if (rxd_s_reg) begin
            state_reg   <= ST_IDLE;
            rx_busy_reg <= 1'b0;
          end
        end
        default: begin
          state_reg   <= ST_IDLE;
          rx_busy_reg <= 1'b0;
        end
      endcase
    end
  end

  assign RX_DATA    = rx_data_reg;
  assign RX_VALID   = rx_valid_reg;
  assign RX_FERR    = rx_ferr_reg;
  assign RX_PERR    = rx_perr_reg;
  assign RX_OVERRUN = rx_overrun_reg;
  assign RX_BUSY    = rx_busy_reg;

endmodule
